instr_mem_loadable: RTL
=======================

// Module: instr_mem_loadable
// PURPOSE
//   Parametrised byte-addressed instruction memory for the IF stage. Word-aligned reads with
//   one registered stage, a stall hold and fault flagging. Image is loaded at run time over a
//   valid/ready stream, so programs are no longer hard-coded in RTL.
//   Sits between the PC register and the IF/ID pipeline register.
// PARAMETERS
//   ADDR_WIDTH  32            byte-address width of the fetch port
//   DATA_WIDTH  32            instruction width; multiple of 8, bytes packed big-endian
//   DEPTH       64            number of instruction words (power of 2, >=2)
//   NOP_WORD    32'h00000000  word driven on a faulted fetch
// PORTS
//   clock        in   1           rising-edge clock
//   reset        in   1           reset, synchronous, active-high
//   fetch_en     in   1           fetch request this cycle
//   stall        in   1           hold instruction/instr_valid/addr_fault
//   address      in   ADDR_WIDTH  byte address of the instruction
//   instruction  out  DATA_WIDTH  fetched word, registered
//   instr_valid  out  1           instruction holds a completed fetch
//   addr_fault   out  1           last fetch was misaligned or out of range
//   load_start   in   1           begin (or restart) image load at word 0
//   load_valid   in   1           load_data valid
//   load_data    in   DATA_WIDTH  next image word
//   load_last    in   1           final word of the image, qualified by load_valid
//   load_ready   out  1           loader accepts a word
//   load_done    out  1           one-cycle pulse: load finished
//   load_count   out  $clog2(DEPTH)+1  words written by the current or last load
//   busy         out  1           load in progress; fetches blocked
// BEHAVIOUR
//   Reset values
//   - Outputs: instruction=NOP_WORD; instr_valid=0, addr_fault=0, load_ready=0, load_done=0,
//     load_count=0, busy=0.
//   - State: IDLE. Memory contents are NOT cleared by reset.
//   State machine
//   - IDLE: serves fetches. load_start -> LOAD, word pointer=0, load_count=0.
//   - LOAD: load_ready=1 and busy=1. A word is written to mem[ptr] on each load_valid&&load_ready
//     cycle; ptr and load_count each increment by 1.
//   - LOAD -> IDLE on the accepted word with load_last=1, or on the word written at ptr==DEPTH-1.
//     load_done pulses in the cycle after that accept; load_ready=0 in the same cycle.
//   - load_start asserted in LOAD restarts the load: ptr=0, load_count=0, and any word presented
//     in that cycle is dropped. load_start has priority over load_valid.
//   Fetch: word index = address[$clog2(DEPTH)+1:2]; latency 1 cycle
//   - If stall=1: all fetch outputs hold, fetch_en is ignored.
//   - Else if busy=1 or fetch_en=0: instr_valid<=0; instruction and addr_fault hold.
//   - Else if address[1:0]!=0, or address >= DEPTH*4 (any upper bit set): instruction<=NOP_WORD,
//     addr_fault<=1, instr_valid<=1.
//   - Else: instruction<=mem[index], addr_fault<=0, instr_valid<=1.
//   Boundaries
//   - A fetch issued in the same cycle as load_start is served from the old contents; the state
//     changes after that edge.
//   - The address DEPTH*4-4 is valid; DEPTH*4 faults. No wrap-around.
//   - Reset asserted mid-load: FSM goes to IDLE, ptr=0. Words already written are kept.
//   - A load longer than DEPTH words never writes beyond DEPTH-1; the FSM exits as stated above.
// TESTING
//   1 Reset, load 4 words A0..A3 with load_last on A3 -> load_count=4, load_done pulses once,
//     fetch 0,4,8,12 -> A0..A3 each 1 cycle later with instr_valid=1.
//   2 Fetch addr=0x6 -> instruction=NOP_WORD, addr_fault=1. Fetch addr=DEPTH*4 -> fault.
//     Fetch DEPTH*4-4 -> stored word, addr_fault=0.
//   3 Fetch addr 8 then 12 with stall=1 in the second cycle -> the word at 8 is held and
//     instr_valid stays 1. Release the stall -> the word at 12 follows.
//   4 Load DEPTH+3 words without load_last -> exit after DEPTH words, load_count=DEPTH,
//     load_ready=0 afterwards.
//   5 Restart with load_start after 2 words, then load B0,B1(last) -> mem[0..1]=B0,B1,
//     load_count=2. Fetches during LOAD -> instr_valid=0.
//   6 Reset after 3 of 5 words -> busy=0, the 3 words are readable, load_done never pulses.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Instruction memory for the IF stage. Run-time loadable over a valid/ready
// stream, one registered read stage with stall hold and fault flagging.
//
// state | meaning
// IDLE  | serving fetches, loader not ready
// LOAD  | accepting image words into mem[ptr], fetches blocked
module instr_mem_loadable #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fetch_en,
  input  logic                        stall,
  input  logic [ADDR_WIDTH-1:0]       address,
  output logic [DATA_WIDTH-1:0]       instruction,
  output logic                        instr_valid,
  output logic                        addr_fault,
  input  logic                        load_start,
  input  logic                        load_valid,
  input  logic [DATA_WIDTH-1:0]       load_data,
  input  logic                        load_last,
  output logic                        load_ready,
  output logic                        load_done,
  output logic [$clog2(DEPTH):0]      load_count,
  output logic                        busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      ptr;
  logic                  accept;
  logic                  final_word;
  logic [IDX_W-1:0]      index;
  logic                  misaligned;
  logic                  out_of_range;

  // A word is taken only in LOAD; a restart request drops any word offered alongside it.
  assign accept     = (state == LOAD) && load_valid && !load_start;
  assign final_word = load_last || (ptr == LAST_IDX);

  assign index        = address[IDX_W+1:2];
  assign misaligned   = (address[1:0] != 2'b00);
  assign out_of_range = ((address >> (IDX_W + 2)) != '0);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: load_start always (re)enters LOAD; the last or DEPTH-th word returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (load_start) state_next = LOAD;
      LOAD: begin
        if (load_start)                 state_next = LOAD;
        else if (accept && final_word)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from state.
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    if (state == LOAD) begin
      load_ready = 1'b1;
      busy       = 1'b1;
    end
  end

  // Loader bookkeeping: write pointer, word count and the completion pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr        <= '0;
      load_count <= '0;
      load_done  <= 1'b0;
    end else begin
      load_done <= accept && final_word;
      if (load_start) begin
        ptr        <= '0;
        load_count <= '0;
      end else if (accept) begin
        ptr        <= ptr + IDX_W'(1);
        load_count <= load_count + CNT_W'(1);
      end
    end
  end

  // Image storage; contents survive reset, and a word offered during reset is not written.
  always_ff @(posedge clock) begin
    if (accept && !reset) mem[ptr] <= load_data;
  end

  // Registered fetch stage with stall hold and fault substitution.
  always_ff @(posedge clock) begin
    if (reset) begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else if (!stall) begin
      if (busy || !fetch_en) begin
        instr_valid <= 1'b0;
      end else if (misaligned || out_of_range) begin
        instruction <= NOP_WORD;
        addr_fault  <= 1'b1;
        instr_valid <= 1'b1;
      end else begin
        instruction <= mem[index];
        addr_fault  <= 1'b0;
        instr_valid <= 1'b1;
      end
    end
  end

endmodule
